// File: rtl/addsub_serial.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, WIDTH/CHUNK cycles per operation.
// Optional signed saturation of the presented result when ADDSUB_SATURATE_EN is defined.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   sum_ext;
    logic             last;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                a_ch = x_q[i*CHUNK +: CHUNK];
                b_ch = y_q[i*CHUNK +: CHUNK];
            end
        end
        sum_ext = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(c_q);
        last    = (k_q == KW'(NCH - 1));
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y ^ {WIDTH{sub}};
                    c_d     = carryin ^ sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (k_q == KW'(i)) s_d[i*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
                end
                c_d = sum_ext[CHUNK];
                if (last) begin
                    // Same operand signs with a differing result sign is C[W] ^ C[W-1].
                    co_d    = sum_ext[CHUNK];
                    ov_d    = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum_ext[CHUNK-1] != x_q[WIDTH-1]);
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign carryout  = co_q;
    assign overflow  = ov_q;

`ifdef ADDSUB_SATURATE_EN
    assign s = (state_q == DONE && ov_q)
             ? (x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
             : s_q;
`else
    assign s = s_q;
`endif

endmodule
